output_unchaining: RTL and testbench
====================================

Name: output_unchaining

Overview:
- Downstream counterpart of the input chaining stage.
- Accepts one wide chained word of OC0 lanes, each DATA_WID bits, from the accumulator/output buffer and serialises it onto a single DATA_WID-bit stream with a valid/ready handshake.
- Lane 0 is the LSB slice and is sent first.
- Pulses done after the last lane of each chained word has been transferred.

Parameters:
- OC0, 4, number of lanes per chained word.
- DATA_WID, 16, bits per lane and per output word.
- COUNTER_WID, 2, lane counter width; must satisfy 2**COUNTER_WID >= OC0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en_output  input  1  level enable; when low, no new load and no output transfer.
- chained_dat  input  DATA_WID*OC0  wide word; lane i = bits [DATA_WID*(i+1)-1 : DATA_WID*i].
- chained_vld  input  1  chained_dat valid.
- chained_rdy  output  1  block can accept chained_dat this cycle.
- output_dat  output  DATA_WID  current lane.
- output_vld  output  1  output_dat valid.
- output_rdy  input  1  downstream accepts output_dat.
- done  output  1  one-cycle pulse after the final lane of a chained word transfers.

Behaviour:
- Reset (async, rst_n low): state=IDLE, lane counter=0, holding register=0, output_vld=0, output_dat=0, done=0, chained_rdy=0. Any word in flight is discarded; no done is issued for it.
- State IDLE:
  - chained_rdy = en_output; output_vld = 0.
  - Load: on a rising edge with chained_vld && chained_rdy, capture chained_dat into the holding register, set counter=0, go to SEND.
- State SEND:
  - output_vld = en_output.
  - output_dat = holding lane[counter]; combinational mux from registers.
  - Transfer: output_vld && output_rdy at a rising edge.
  - Non-last transfer (counter != OC0-1): counter increments.
  - Last transfer (counter == OC0-1): counter returns to 0; done is registered high for exactly the next cycle.
  - After last transfer, with reload: if chained_vld && chained_rdy in the same cycle, load the new word and stay in SEND. This gives back-to-back operation with no bubble.
  - After last transfer, no reload: go to IDLE.
  - chained_rdy in SEND = en_output && (counter == OC0-1) && output_rdy. This is a combinational path from output_rdy; documented as intended.
- Backpressure: output_rdy low holds counter and output_dat stable, and output_vld stays high while en_output=1.
- en_output low mid-word: output_vld drops, counter frozen, holding register kept. Resumes at the same lane when en_output returns high. No lane is lost or duplicated.
- chained_vld while busy (SEND, not last transfer): ignored; chained_rdy=0. Upstream must hold the word.
- Latency: first lane appears on output_dat/output_vld in the cycle after load. Minimum OC0 cycles per chained word.
- done timing: high in the cycle after the last transfer, even if a new word was loaded on that edge.
- Counter arithmetic: wraps only by explicit reset to 0 at OC0-1, never by overflow. Unused counter codes are unreachable.

Test Plan:
- Basic serialisation:
  - Stimulus: OC0=4, DATA_WID=16, load chained_dat=0x0004_0003_0002_0001, output_rdy=1.
  - Required: outputs 1,2,3,4 on four consecutive cycles starting one cycle after load; done high for one cycle after 4; returns to IDLE with chained_rdy=1.
- Backpressure:
  - Stimulus: same word, output_rdy low for 2 cycles while output_dat=2.
  - Required: output_dat holds 2 with output_vld=1 throughout; sequence still 1,2,3,4; single done.
- Enable drop:
  - Stimulus: deassert en_output for 3 cycles after lane 1 (value 2) transfers.
  - Required: output_vld=0 during the drop; on re-enable output_dat=3 then 4; done once.
- Back-to-back loads:
  - Stimulus: chained_vld held high with 0x0004_0003_0002_0001 then 0x0008_0007_0006_0005.
  - Required: outputs 1..8 on 8 consecutive cycles with no bubble; done pulses after 4 and after 8; chained_rdy high only on the last-lane cycles.
- Busy ignore:
  - Stimulus: chained_vld asserted with a new word while lane 1 is pending.
  - Required: chained_rdy=0; the word is not captured until the last lane transfers.
- Reset mid-word:
  - Stimulus: assert rst_n=0 asynchronously (between edges) after lane 1 transfers.
  - Required: output_vld, done, chained_rdy and output_dat go to 0 immediately. After release, chained_rdy=1 when en_output=1, and the next load starts from lane 0 with no spurious done.

Source files
------------

// File: rtl/output_unchaining.sv
// Serialises one wide chained word of OC0 lanes onto a narrow stream.
// Lane 0 goes first; done pulses the cycle after the last lane transfers.
module output_unchaining #(
    parameter int OC0         = 4,
    parameter int DATA_WID    = 16,
    parameter int COUNTER_WID = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_output,
    input  logic [DATA_WID*OC0-1:0] chained_dat,
    input  logic                    chained_vld,
    output logic                    chained_rdy,
    output logic [DATA_WID-1:0]     output_dat,
    output logic                    output_vld,
    input  logic                    output_rdy,
    output logic                    done
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [COUNTER_WID-1:0] LAST = COUNTER_WID'(OC0 - 1);
    localparam logic [COUNTER_WID-1:0] ONE  = COUNTER_WID'(1);

    state_t                          state;
    state_t                          state_nxt;
    logic [COUNTER_WID-1:0]          cnt;
    logic [OC0-1:0][DATA_WID-1:0]    hold;
    logic                            done_q;

    logic is_last;
    logic xfer;
    logic load;

    assign is_last = (cnt == LAST);
    assign xfer    = output_vld && output_rdy;
    assign load    = chained_vld && chained_rdy;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Lane counter, holding register and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            hold   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= xfer && is_last;
            if (load) begin
                hold <= chained_dat;
                cnt  <= '0;
            end else if (xfer) begin
                cnt <= is_last ? '0 : cnt + ONE;
            end
        end
    end

    // Next-state: reload after the last lane keeps us in SEND with no bubble
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (load) state_nxt = SEND;
            end
            SEND: begin
                if (xfer && is_last && !load) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: chained_rdy in SEND depends combinationally on output_rdy
    always_comb begin
        chained_rdy = 1'b0;
        output_vld  = 1'b0;
        output_dat  = hold[cnt];
        done        = done_q;
        unique case (state)
            IDLE: begin
                chained_rdy = rst_n && en_output;
            end
            SEND: begin
                output_vld  = en_output;
                chained_rdy = en_output && is_last && output_rdy;
            end
            default: begin
                chained_rdy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_output_unchaining.sv
// Directed testbench for output_unchaining.
// Observes {output_vld, chained_rdy, done, output_dat} once per cycle.
module tb_output_unchaining;

    localparam logic [63:0] W1 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] W2 = 64'h0008_0007_0006_0005;

    logic        clk;
    logic        rst_n;
    logic        en_output;
    logic [63:0] chained_dat;
    logic        chained_vld;
    logic        chained_rdy;
    logic [15:0] output_dat;
    logic        output_vld;
    logic        output_rdy;
    logic        done;

    int n_cmp;
    int n_err;

    logic [18:0] obs;
    logic [18:0] exp_v;

    assign obs = {output_vld, chained_rdy, done, output_dat};

    output_unchaining #(
        .OC0(4),
        .DATA_WID(16),
        .COUNTER_WID(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en_output(en_output),
        .chained_dat(chained_dat),
        .chained_vld(chained_vld),
        .chained_rdy(chained_rdy),
        .output_dat(output_dat),
        .output_vld(output_vld),
        .output_rdy(output_rdy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] ex(
        input logic v, input logic r, input logic d, input logic [15:0] dt
    );
        return {v, r, d, dt};
    endfunction

    task automatic test_reset();
        rst_n       = 1'b0;
        en_output   = 1'b1;
        chained_vld = 1'b0;
        chained_dat = '0;
        output_rdy  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        exp_v = ex(1'b0, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_hold: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_v = ex(1'b0, 1'b1, 1'b0, 16'h0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_release: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        chained_vld = 1'b1;
        chained_dat = W1;
        @(negedge clk);
        chained_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_v = ex(1'b1, (i == 3), 1'b0, 16'(i + 1));
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL basic_lane%0d: got %h want %h", i, obs, exp_v);
            end
            @(negedge clk);
        end
        #1;
        exp_v = ex(1'b0, 1'b1, 1'b1, 16'h1);
        n_cmp++;
        if (obs[18:16] !== exp_v[18:16]) begin
            n_err++;
            $display("FAIL basic_done: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0 || chained_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_idle: got done=%b rdy=%b want 0 1",
                     done, chained_rdy);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [15:0] seq [7];
        logic        rdy [7];
        int          ndone;
        seq = '{16'h1, 16'h2, 16'h2, 16'h2, 16'h3, 16'h4, 16'h0};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ndone = 0;
        chained_vld = 1'b1;
        chained_dat = W1;
        @(negedge clk);
        chained_vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            output_rdy = rdy[i];
            #1;
            if (done) ndone++;
            n_cmp++;
            if (output_vld !== 1'b1 || output_dat !== seq[i]) begin
                n_err++;
                $display("FAIL bp_step%0d: got vld=%b dat=%h want 1 %h",
                         i, output_vld, output_dat, seq[i]);
            end
            @(negedge clk);
        end
        #1;
        if (done) ndone++;
        @(negedge clk);
        #1;
        if (done) ndone++;
        n_cmp++;
        if (ndone != 1) begin
            n_err++;
            $display("FAIL bp_done_count: got %0d want 1", ndone);
        end
        @(negedge clk);
    endtask

    task automatic test_enable_drop();
        int ndone;
        ndone = 0;
        chained_vld = 1'b1;
        chained_dat = W1;
        @(negedge clk);
        chained_vld = 1'b0;
        #1;
        n_cmp++;
        if (output_dat !== 16'h1) begin
            n_err++;
            $display("FAIL en_lane0: got %h want 0001", output_dat);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (output_dat !== 16'h2) begin
            n_err++;
            $display("FAIL en_lane1: got %h want 0002", output_dat);
        end
        @(negedge clk);
        en_output = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp_v = ex(1'b0, 1'b0, 1'b0, 16'h3);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL en_drop%0d: got %h want %h", i, obs, exp_v);
            end
            @(negedge clk);
        end
        en_output = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (done) ndone++;
            exp_v = ex(1'b1, (i == 1), 1'b0, 16'(i + 3));
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL en_resume%0d: got %h want %h", i, obs, exp_v);
            end
            @(negedge clk);
        end
        #1;
        if (done) ndone++;
        @(negedge clk);
        #1;
        if (done) ndone++;
        n_cmp++;
        if (ndone != 1) begin
            n_err++;
            $display("FAIL en_done_count: got %0d want 1", ndone);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        chained_vld = 1'b1;
        chained_dat = W1;
        @(negedge clk);
        chained_dat = W2;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_v = ex(1'b1, (i % 4 == 3), (i == 4), 16'(i + 1));
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL b2b_lane%0d: got %h want %h", i, obs, exp_v);
            end
            if (i == 4) chained_vld = 1'b0;
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (done !== 1'b1 || output_vld !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done: got done=%b vld=%b want 1 0",
                     done, output_vld);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        chained_vld = 1'b1;
        chained_dat = W1;
        @(negedge clk);
        chained_vld = 1'b0;
        @(negedge clk);
        chained_vld = 1'b1;
        chained_dat = W2;
        output_rdy  = 1'b0;
        #1;
        exp_v = ex(1'b1, 1'b0, 1'b0, 16'h2);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL busy_stall: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        output_rdy = 1'b1;
        #1;
        exp_v = ex(1'b1, 1'b0, 1'b0, 16'h2);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL busy_held: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        #1;
        exp_v = ex(1'b1, 1'b0, 1'b0, 16'h3);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL busy_lane2: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        #1;
        exp_v = ex(1'b1, 1'b1, 1'b0, 16'h4);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL busy_lane3: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        chained_vld = 1'b0;
        #1;
        exp_v = ex(1'b1, 1'b0, 1'b1, 16'h5);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL busy_reload: got %h want %h", obs, exp_v);
        end
        repeat (4) @(negedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b1 || output_vld !== 1'b0) begin
            n_err++;
            $display("FAIL busy_done: got done=%b vld=%b want 1 0",
                     done, output_vld);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_word();
        int ndone;
        ndone = 0;
        chained_vld = 1'b1;
        chained_dat = W1;
        @(negedge clk);
        chained_vld = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_v = ex(1'b0, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL rst_async: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_v = ex(1'b0, 1'b1, 1'b0, 16'h0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL rst_after: got %h want %h", obs, exp_v);
        end
        chained_vld = 1'b1;
        chained_dat = W2;
        @(negedge clk);
        chained_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (done) ndone++;
            exp_v = ex(1'b1, (i == 3), 1'b0, 16'(i + 5));
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL rst_lane%0d: got %h want %h", i, obs, exp_v);
            end
            @(negedge clk);
        end
        #1;
        if (done) ndone++;
        n_cmp++;
        if (ndone != 1 || done !== 1'b1) begin
            n_err++;
            $display("FAIL rst_done: got count=%0d done=%b want 1 1",
                     ndone, done);
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_enable_drop();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
